seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_pkg.sv | 25 ++
 rtl/seq_multiplier_shift_left.sv | 23 ++
 rtl/seq_multiplier.sv | 129 ++++++++++++
 tb/tb_seq_multiplier.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier_pkg
// Description : Shared constants and state encoding for the sequential
//               shift-and-add multiplier and its ALU/control path.
// Contents    : SM_N           operand/product width
//               SM_ITERATIONS  number of RUN iterations
//               SM_CNT_W       width of the iteration counter
//               sm_state_e     IDLE / RUN / DONE state encoding
// Revision    : 1.0  initial release
// ============================================================================
package seq_multiplier_pkg;

    localparam int SM_N          = 32;
    localparam int SM_ITERATIONS = 32;
    localparam int SM_CNT_W      = $clog2(SM_ITERATIONS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sm_state_e;

endpackage : seq_multiplier_pkg
`default_nettype wire

// File: rtl/seq_multiplier_shift_left.sv
`default_nettype none
// ============================================================================
// Module      : shift_left
// Description : Purely combinational logical left shift; bits shifted out
//               past the top are discarded.
// Ports       : in     [W-1:0]   value to shift
//               shift  [SW-1:0]  shift distance
//               out    [W-1:0]   in << shift, truncated to W bits
// Revision    : 1.0  initial release
// ============================================================================
module shift_left #(
    parameter int W  = 32,
    parameter int SW = 5
) (
    input  logic [W-1:0]  in,
    input  logic [SW-1:0] shift,
    output logic [W-1:0]  out
);

    assign out = in << shift;

endmodule : shift_left
`default_nettype wire

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_multiplier
// Description : Unsigned 32x32 -> 32 (low word) sequential multiplier.
//               One shift-and-add iteration per clock; 32 iterations per
//               operation regardless of operand values.
// Ports       : clk      single clock, rising edge
//               rst      asynchronous active-high reset
//               start    request a multiply (sampled in IDLE or DONE)
//               a, b     multiplicand / multiplier, captured on acceptance
//               busy     high while iterating (RUN)
//               done     one-cycle pulse, product valid
//               product  low N bits of a*b, held until the next done
// Revision    : 1.0  initial release
// ============================================================================
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int N = SM_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product
);

    localparam logic [SM_CNT_W-1:0] LAST_CNT = SM_CNT_W'(SM_ITERATIONS - 1);

    sm_state_e           state_q, state_d;
    logic [SM_CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]        a_reg_q, a_reg_d;
    logic [N-1:0]        b_reg_q, b_reg_d;
    logic [N-1:0]        acc_q, acc_d;
    logic [N-1:0]        product_q, product_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [N-1:0]        shifted;
    logic [N-1:0]        addend;
    logic [N-1:0]        acc_sum;

    shift_left #(
        .W  (N),
        .SW (SM_CNT_W)
    ) u_shift_left (
        .in    (a_reg_q),
        .shift (cnt_q),
        .out   (shifted)
    );

    // Partial product for this iteration; the add wraps modulo 2^N.
    assign addend  = b_reg_q[cnt_q] ? shifted : '0;
    assign acc_sum = acc_q + addend;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_reg_d   = a_reg_q;
        b_reg_d   = b_reg_q;
        acc_d     = acc_q;
        product_d = product_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_reg_d = a;
                    b_reg_d = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            RUN: begin
                // start is deliberately not looked at here.
                acc_d = acc_sum;
                cnt_d = cnt_q + SM_CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    // Last iteration: publish the sum including this step's add.
                    product_d = acc_sum;
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_reg_q   <= '0;
            b_reg_q   <= '0;
            acc_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_reg_q   <= a_reg_d;
            b_reg_q   <= b_reg_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule : seq_multiplier
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_multiplier
// Description : Self-checking bench for seq_multiplier. Expected products come
//               from a plain 64-bit multiply truncated to the low word; timing
//               expectations come from the documented 32-edge latency.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seq_multiplier;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] prev_product;

    seq_multiplier #(.N(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: low word of the full-width unsigned product.
    function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] full;
        full = {32'd0, x} * {32'd0, y};
        return full[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full operation with start pulsed for one cycle; inputs are scrambled
    // and start is toggled randomly while RUN is in progress.
    task automatic run_op(input logic [31:0] ai, input logic [31:0] bi, input string tag);
        logic [31:0] exp;
        exp   = ref_mul(ai, bi);
        a     = ai;
        b     = bi;
        start = 1'b1;
        step();                                   // E0
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        check({tag, "_done_e0"}, {31'd0, done}, 32'd0);
        for (int i = 1; i < 32; i++) begin
            start = 1'($urandom_range(0, 1));
            a     = $urandom;
            b     = $urandom;
            step();                               // E1..E31
            check($sformatf("%s_busy_e%0d", tag, i), {31'd0, busy}, 32'd1);
            check($sformatf("%s_done_e%0d", tag, i), {31'd0, done}, 32'd0);
            check($sformatf("%s_hold_e%0d", tag, i), product, prev_product);
        end
        start = 1'b0;
        step();                                   // E32
        check({tag, "_done_e32"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_e32"}, {31'd0, busy}, 32'd0);
        check({tag, "_product"}, product, exp);
        prev_product = exp;
        step();                                   // E33
        check({tag, "_done_e33"}, {31'd0, done}, 32'd0);
        check({tag, "_busy_e33"}, {31'd0, busy}, 32'd0);
        check({tag, "_product_held"}, product, exp);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        a            = '0;
        b            = '0;
        prev_product = '0;

        // Reset state before any clock edge.
        #2;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_product", product, 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First start right after reset release.
        run_op(32'd3, 32'd5, "mul_3x5");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff");
        run_op(32'h0001_0000, 32'h0001_0000, "mul_wrap");
        run_op(32'h1234_5678, 32'd7, "mul_pre");
        run_op(32'h1234_5678, 32'd0, "mul_bzero");

        // Idle period: nothing should move.
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_busy", {31'd0, busy}, 32'd0);
            check("idle_done", {31'd0, done}, 32'd0);
        end

        // Back-to-back with start held high.
        a     = 32'd2;
        b     = 32'd7;
        start = 1'b1;
        step();                                   // E0
        for (int i = 1; i <= 31; i++) begin
            a = $urandom;
            b = $urandom;
            step();
            check("b2b_busy1", {31'd0, busy}, 32'd1);
        end
        step();                                   // E32
        check("b2b_done_e32", {31'd0, done}, 32'd1);
        check("b2b_product1", product, 32'd14);
        a = 32'd4;
        b = 32'd9;
        step();                                   // E33: restart accepted
        check("b2b_busy_e33", {31'd0, busy}, 32'd1);
        check("b2b_done_e33", {31'd0, done}, 32'd0);
        check("b2b_hold_e33", product, 32'd14);
        for (int i = 34; i <= 64; i++) begin
            a = $urandom;
            b = $urandom;
            step();
            check("b2b_busy2", {31'd0, busy}, 32'd1);
            check("b2b_done2", {31'd0, done}, 32'd0);
            check("b2b_hold2", product, 32'd14);
        end
        start = 1'b0;
        step();                                   // E65
        check("b2b_done_e65", {31'd0, done}, 32'd1);
        check("b2b_product2", product, 32'd36);
        step();                                   // E66
        check("b2b_done_e66", {31'd0, done}, 32'd0);
        check("b2b_busy_e66", {31'd0, busy}, 32'd0);
        prev_product = 32'd36;

        // Reset in the middle of an operation.
        a     = 32'd6;
        b     = 32'd7;
        start = 1'b1;
        step();                                   // E0, cnt=0
        start = 1'b0;
        for (int i = 1; i <= 10; i++) step();     // cnt=10
        check("rstmid_busy_before", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_product", product, 32'd0);
        prev_product = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rstheld_done", {31'd0, done}, 32'd0);
            check("rstheld_busy", {31'd0, busy}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 34; i++) begin
            step();
            check("post_rst_no_done", {31'd0, done}, 32'd0);
        end
        run_op(32'd6, 32'd7, "mul_after_rst");

        // Randomized operands against the reference multiply.
        for (int i = 0; i < 8; i++) begin
            run_op($urandom, $urandom, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_multiplier
`default_nettype wire
